// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output-feature-map path.
// Holds the default map geometry (DATA_WIDTH, OFM_SIZE, NUM_CH), the writer
// FSM state encoding, and a small width helper.
package cnn_pkg;

   localparam int CNN_DATA_WIDTH = 8;
   localparam int CNN_OFM_SIZE   = 16;
   localparam int CNN_NUM_CH     = 128;

   // IDLE waits for finish, WRITE streams rows, NEXT advances the channel.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      NEXT  = 2'd2
   } ofm_state_e;

   // Index width for n items, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ofm_row_mux.sv
// Combinational row selector for the captured output feature map.
// Ports:
//   map      - full captured map, row i at bits [i*ROW_BITS +: ROW_BITS]
//   row      - row index to select
//   row_data - selected row, column j at bits [j*DATA_WIDTH +: DATA_WIDTH]
module ofm_row_mux
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int OFM_SIZE   = CNN_OFM_SIZE,
   parameter int ROW_W      = idx_width(CNN_OFM_SIZE)
) (
   input  logic [DATA_WIDTH*OFM_SIZE*OFM_SIZE-1:0] map,
   input  logic [ROW_W-1:0]                        row,
   output logic [DATA_WIDTH*OFM_SIZE-1:0]          row_data
);

   localparam int ROW_BITS = DATA_WIDTH * OFM_SIZE;

   always_comb begin
      row_data = '0;
      for (int i = 0; i < OFM_SIZE; i++) begin
         if (row == ROW_W'(i)) begin
            row_data = map[i*ROW_BITS +: ROW_BITS];
         end
      end
   end

endmodule

// File: rtl/ofm_writer.sv
// Output feature map writer.
// Captures one pooled map when the engine pulses finish, then writes it to
// memory one row per accepted request, advancing the output channel after the
// last row. A layer_done pulse marks completion of channel NUM_CH-1.
// Optional build macro OFM_WRITER_CHKSUM_EN adds a 16-bit running pixel sum.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   finish      - engine pulse: ofm is valid this cycle
//   ofm         - full pooled map, pixel (i,j) at [(OFM_SIZE*i+j)*DATA_WIDTH +: DATA_WIDTH]
//   ch_idx      - current output channel (kernel/bias select)
//   wr          - memory write request
//   wr_addr     - word address, ch_idx*OFM_SIZE + row
//   wr_data     - one map row
//   wr_ready    - memory accepts when wr && wr_ready
//   busy        - map is being written
//   layer_done  - one-cycle pulse after the last channel's last row
//   overrun     - sticky: finish arrived while not idle
//   chksum      - (OFM_WRITER_CHKSUM_EN only) wrapping sum of accepted pixels
module ofm_writer
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int OFM_SIZE   = CNN_OFM_SIZE,
   parameter int NUM_CH     = CNN_NUM_CH,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    finish,
   input  logic [DATA_WIDTH*OFM_SIZE*OFM_SIZE-1:0] ofm,
   output logic [6:0]                              ch_idx,
   output logic                                    wr,
   output logic [ADDR_WIDTH-1:0]                   wr_addr,
   output logic [DATA_WIDTH*OFM_SIZE-1:0]          wr_data,
   input  logic                                    wr_ready,
   output logic                                    busy,
   output logic                                    layer_done,
`ifdef OFM_WRITER_CHKSUM_EN
   output logic [15:0]                             chksum,
`endif
   output logic                                    overrun
);

   localparam int ROW_W    = idx_width(OFM_SIZE);
   localparam int MAP_BITS = DATA_WIDTH * OFM_SIZE * OFM_SIZE;

   ofm_state_e             state_q, state_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [6:0]             ch_q, ch_d;
   logic [MAP_BITS-1:0]    buf_q;
   logic                   overrun_q;
   logic                   capture;
   logic                   accept;
   logic                   last_ch;

   // Only a finish seen in IDLE is captured; anything later is an overrun.
   assign capture = (state_q == IDLE) && finish;
   assign accept  = (state_q == WRITE) && wr_ready;
   assign last_ch = (ch_q == 7'(NUM_CH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_q     <= '0;
         ch_q      <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         ch_q      <= ch_d;
         overrun_q <= overrun_q | (finish && (state_q != IDLE));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
      end else if (capture) begin
         buf_q <= ofm;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      ch_d    = ch_q;
      unique case (state_q)
         IDLE: begin
            if (finish) begin
               row_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (wr_ready) begin
               if (row_q == ROW_W'(OFM_SIZE - 1)) begin
                  state_d = NEXT;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
         end
         NEXT: begin
            ch_d    = last_ch ? 7'd0 : ch_q + 7'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request outputs are decoded from registered state, so they hold
   // naturally until the row is accepted.
   ofm_row_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .OFM_SIZE   (OFM_SIZE),
      .ROW_W      (ROW_W)
   ) u_row_mux (
      .map      (buf_q),
      .row      (row_q),
      .row_data (wr_data)
   );

   assign wr         = (state_q == WRITE);
   assign busy       = (state_q == WRITE);
   assign layer_done = (state_q == NEXT) && last_ch;
   assign wr_addr    = ADDR_WIDTH'(32'(ch_q) * 32'(OFM_SIZE) + 32'(row_q));
   assign ch_idx     = ch_q;
   assign overrun    = overrun_q;

`ifdef OFM_WRITER_CHKSUM_EN
   logic [15:0] row_sum;
   logic [15:0] chksum_q;

   always_comb begin
      row_sum = '0;
      for (int j = 0; j < OFM_SIZE; j++) begin
         row_sum = row_sum + 16'(wr_data[j*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // layer_done and acceptance never coincide, so clearing wins trivially.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chksum_q <= '0;
      end else if (layer_done) begin
         chksum_q <= '0;
      end else if (accept) begin
         chksum_q <= chksum_q + row_sum;
      end
   end

   assign chksum = chksum_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ofm_writer.sv
// Directed self-checking bench for ofm_writer (default geometry 8b x 16x16, 128 ch).
module tb_ofm_writer;

   logic          clk;
   logic          rst_n;
   logic          finish;
   logic [2047:0] ofm;
   logic [6:0]    ch_idx;
   logic          wr;
   logic [10:0]   wr_addr;
   logic [127:0]  wr_data;
   logic          wr_ready;
   logic          busy;
   logic          layer_done;
   logic          overrun;
`ifdef OFM_WRITER_CHKSUM_EN
   logic [15:0]   chksum;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Results of the most recent drive_channel call.
   int            cap_n;
   logic [10:0]   cap_addr [32];
   logic [127:0]  cap_data [32];
   int            hold_viol;
   int            ld_cnt;
   int            first_wr_c;
   bit            timed_out;

   ofm_writer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .finish     (finish),
      .ofm        (ofm),
      .ch_idx     (ch_idx),
      .wr         (wr),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .busy       (busy),
      .layer_done (layer_done),
`ifdef OFM_WRITER_CHKSUM_EN
      .chksum     (chksum),
`endif
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // pixel(i,j) = base + 16*i + j (mod 256), or base everywhere when flat.
   function automatic logic [2047:0] make_ofm(input int base, input bit flat);
      logic [2047:0] v;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            v[(16*i+j)*8 +: 8] = flat ? 8'(base) : 8'(base + 16*i + j);
      return v;
   endfunction

   function automatic logic [127:0] exp_row(input int base, input int r);
      logic [127:0] v;
      for (int j = 0; j < 16; j++) v[j*8 +: 8] = 8'(base + 16*r + j);
      return v;
   endfunction

   // Pulse finish with first_ofm, then run the write with wr_ready either
   // always high or low on alternate cycles, recording accepted writes.
   // second_c >= 0 raises finish again (with second_ofm) at that loop cycle.
   // Returns at the first negedge back in IDLE after the 16th acceptance.
   task automatic drive_channel(input logic [2047:0] first_ofm, input bit alt,
                                input int second_c, input logic [2047:0] second_ofm);
      int           post;
      bit           ready;
      bit           pend;
      logic [10:0]  p_addr;
      logic [127:0] p_data;
      cap_n = 0; hold_viol = 0; ld_cnt = 0; first_wr_c = -1; timed_out = 1'b1;
      post = 0; pend = 1'b0; p_addr = '0; p_data = '0;
      ofm = first_ofm; finish = 1'b1; wr_ready = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (c == second_c) begin
            ofm = second_ofm; finish = 1'b1;
         end else begin
            finish = 1'b0;
         end
         if (pend && (wr !== 1'b1 || wr_addr !== p_addr || wr_data !== p_data)) hold_viol++;
         if (layer_done === 1'b1) ld_cnt++;
         ready = alt ? c[0] : 1'b1;
         wr_ready = ready;
         if (wr === 1'b1 && first_wr_c < 0) first_wr_c = c;
         if (wr === 1'b1 && ready) begin
            if (cap_n < 32) begin
               cap_addr[cap_n] = wr_addr;
               cap_data[cap_n] = wr_data;
            end
            cap_n++;
         end
         pend = (wr === 1'b1) && !ready;
         p_addr = wr_addr; p_data = wr_data;
         if (cap_n >= 16) post++;
         if (post == 3) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      finish = 1'b0; wr_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; finish = 1'b0; wr_ready = 1'b1; ofm = make_ofm(0, 1'b0);
      repeat (3) @(negedge clk);
      n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", wr); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (ch_idx !== 7'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", ch_idx); end
      n_checks++; if (wr_addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", wr_addr); end
      n_checks++; if (wr_data !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", wr_data); end
      n_checks++; if (layer_done !== 1'b0) begin n_fail++; $display("FAIL reset_ld: got %b want 0", layer_done); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL idle_no_wr: got %b want 0", wr); end
   endtask

   task automatic test_single_channel();
      drive_channel(make_ofm(0, 1'b0), 1'b0, -1, '0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL single_timeout: got %0d writes want 16", cap_n); end
      n_checks++; if (cap_n !== 16) begin n_fail++; $display("FAIL single_count: got %0d want 16", cap_n); end
      n_checks++; if (first_wr_c !== 0) begin n_fail++; $display("FAIL single_latency: got %0d want 0", first_wr_c); end
      for (int r = 0; r < 16 && r < cap_n; r++) begin
         n_checks++;
         if (cap_addr[r] !== 11'(r)) begin
            n_fail++; $display("FAIL single_addr[%0d]: got %0d want %0d", r, cap_addr[r], r);
         end
         n_checks++;
         if (cap_data[r] !== exp_row(0, r)) begin
            n_fail++; $display("FAIL single_data[%0d]: got %h want %h", r, cap_data[r], exp_row(0, r));
         end
      end
      n_checks++; if (ch_idx !== 7'd1) begin n_fail++; $display("FAIL single_ch: got %0d want 1", ch_idx); end
      n_checks++; if (ld_cnt !== 0) begin n_fail++; $display("FAIL single_ld: got %0d want 0", ld_cnt); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      drive_channel(make_ofm(5, 1'b0), 1'b1, -1, '0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got %0d writes want 16", cap_n); end
      n_checks++; if (cap_n !== 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", cap_n); end
      n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d violations want 0", hold_viol); end
      for (int r = 0; r < 16 && r < cap_n; r++) begin
         n_checks++;
         if (cap_addr[r] !== 11'(16 + r)) begin
            n_fail++; $display("FAIL bp_addr[%0d]: got %0d want %0d", r, cap_addr[r], 16 + r);
         end
         n_checks++;
         if (cap_data[r] !== exp_row(5, r)) begin
            n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", r, cap_data[r], exp_row(5, r));
         end
      end
      n_checks++; if (ch_idx !== 7'd2) begin n_fail++; $display("FAIL bp_ch: got %0d want 2", ch_idx); end
   endtask

   task automatic test_overrun();
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b want 0", overrun); end
      drive_channel(make_ofm(40, 1'b0), 1'b0, 2, make_ofm(200, 1'b1));
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      n_checks++; if (cap_n !== 16) begin n_fail++; $display("FAIL ovr_count: got %0d want 16", cap_n); end
      for (int r = 0; r < 16 && r < cap_n; r++) begin
         n_checks++;
         if (cap_data[r] !== exp_row(40, r)) begin
            n_fail++; $display("FAIL ovr_data[%0d]: got %h want %h", r, cap_data[r], exp_row(40, r));
         end
      end
      n_checks++; if (ch_idx !== 7'd3) begin n_fail++; $display("FAIL ovr_ch: got %0d want 3", ch_idx); end
      repeat (3) @(negedge clk);
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_reset_mid_write();
      bit found;
      int stray;
      found = 1'b0; stray = 0;
      ofm = make_ofm(0, 1'b0); wr_ready = 1'b1; finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (wr === 1'b1 && wr_addr === 11'd53) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL rst_row5: got no write at addr 53 want one"); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b want 0", wr); end
      n_checks++; if (ch_idx !== 7'd0) begin n_fail++; $display("FAIL rst_ch: got %0d want 0", ch_idx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (wr_addr !== 11'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", wr_addr); end
      n_checks++; if (wr_data !== 128'd0) begin n_fail++; $display("FAIL rst_data: got %h want 0", wr_data); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b want 0", overrun); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wr === 1'b1) stray++;
      end
      n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rst_stray: got %0d writes want 0", stray); end
   endtask

   task automatic test_full_layer();
      int bad;
      int ld_total;
      int ld_ch;
      logic [10:0] last_addr;
      bad = 0; ld_total = 0; ld_ch = -1; last_addr = '0;
      for (int ch = 0; ch < 128; ch++) begin
         drive_channel(make_ofm(ch, 1'b0), 1'b0, -1, '0);
         if (timed_out || cap_n != 16) bad++;
         for (int r = 0; r < 16 && r < cap_n; r++)
            if (cap_addr[r] !== 11'(ch*16 + r)) bad++;
         if (cap_n > 0 && cap_n <= 32) last_addr = cap_addr[cap_n-1];
         if (ld_cnt != 0) ld_ch = ch;
         ld_total += ld_cnt;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL layer_addrs: got %0d bad want 0", bad); end
      n_checks++; if (last_addr !== 11'd2047) begin n_fail++; $display("FAIL layer_last: got %0d want 2047", last_addr); end
      n_checks++; if (ld_total !== 1) begin n_fail++; $display("FAIL layer_done_cnt: got %0d want 1", ld_total); end
      n_checks++; if (ld_ch !== 127) begin n_fail++; $display("FAIL layer_done_ch: got %0d want 127", ld_ch); end
      n_checks++; if (ch_idx !== 7'd0) begin n_fail++; $display("FAIL layer_wrap: got %0d want 0", ch_idx); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL layer_ovr: got %b want 0", overrun); end
`ifdef OFM_WRITER_CHKSUM_EN
      n_checks++; if (chksum !== 16'd0) begin n_fail++; $display("FAIL layer_chk_clr: got %h want 0000", chksum); end
`endif
   endtask

`ifdef OFM_WRITER_CHKSUM_EN
   task automatic test_chksum();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (chksum !== 16'd0) begin n_fail++; $display("FAIL chk_reset: got %h want 0000", chksum); end
      drive_channel(make_ofm(8'h7f, 1'b1), 1'b0, -1, '0);
      n_checks++; if (chksum !== 16'h7f00) begin n_fail++; $display("FAIL chk_sum: got %h want 7f00", chksum); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_channel();
      test_backpressure();
      test_overrun();
      test_reset_mid_write();
      test_full_layer();
`ifdef OFM_WRITER_CHKSUM_EN
      test_chksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ofm_writer.md
OFM_WRITER -- requirements
Module: ofm_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per pooled output pixel.
REQ-002 Parameter OFM_SIZE, default 16, pooled map edge in pixels, giving OFM_SIZE rows of OFM_SIZE pixels.
REQ-003 Parameter NUM_CH, default 128, output channels (kernels) per layer.
REQ-004 Parameter ADDR_WIDTH, default 11, memory word address width, equal to log2(NUM_CH*OFM_SIZE).
REQ-005 Port clk, input, 1, clock; rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port finish, input, 1, single-cycle pulse from the conv/pool engine: ofm valid this cycle.
REQ-007 Port ofm, input, DATA_WIDTH*OFM_SIZE*OFM_SIZE, pixel (i,j) at bits [(OFM_SIZE*i+j+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-008 Port ch_idx, output, 7, current output channel; drives the engine's kernel/bias select.
REQ-009 Port wr, output, 1, memory write request.
REQ-010 Port wr_addr, output, ADDR_WIDTH, word address = ch_idx*OFM_SIZE + row.
REQ-011 Port wr_data, output, DATA_WIDTH*OFM_SIZE, one row, column j at bits [(j+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-012 Port wr_ready, input, 1, memory accepts the write on a cycle where wr && wr_ready.
REQ-013 Port busy, output, 1, high while the captured map is being written.
REQ-014 Port layer_done, output, 1, one-cycle pulse after the last row of channel NUM_CH-1 is accepted.
REQ-015 Port overrun, output, 1, sticky flag: finish arrived while busy.

Function
REQ-016 On finish in IDLE, the block shall register the full ofm into a capture buffer, set row=0, and enter WRITE the next cycle.
REQ-017 In WRITE, wr shall be high, with wr_data = buffered row `row` and wr_addr = ch_idx*OFM_SIZE+row.
REQ-018 wr, wr_addr, and wr_data shall hold stable until wr_ready is sampled high.
REQ-019 On acceptance with row<OFM_SIZE-1, row shall increment; back-to-back acceptance shall yield one row per cycle.
REQ-020 On acceptance of row OFM_SIZE-1, the block shall enter NEXT, deassert wr, and clear busy.
REQ-021 In NEXT, if ch_idx<NUM_CH-1, ch_idx shall increment and the state shall go to IDLE.
REQ-022 In NEXT with ch_idx=NUM_CH-1, the block shall pulse layer_done for one cycle, wrap ch_idx to 0, and go to IDLE.
REQ-023 busy shall be high in WRITE only.
REQ-024 Minimum finish-to-first-wr latency shall be 1 cycle.
REQ-025 finish while busy or in NEXT shall be ignored (buffer unchanged) and shall set overrun, which clears only on reset.
REQ-026 ch_idx shall change only in NEXT, so bias/kernel selection stays stable during a channel's compute and write.

Reset
REQ-027 rst_n low shall force, asynchronously, state=IDLE, ch_idx=0, row=0, wr=0, wr_addr=0, wr_data=0, busy=0, layer_done=0, overrun=0, and capture buffer=0.
REQ-028 Reset during WRITE shall abandon the transfer with no further wr pulses after release until a new finish arrives.

Configuration
REQ-029 With OFM_WRITER_CHKSUM_EN defined, the block shall add output chksum, 16 bits: the wrapping sum of every accepted pixel taken as unsigned.
REQ-030 chksum shall clear on reset and on the cycle after layer_done, and shall update on each accepted row.
REQ-031 Without OFM_WRITER_CHKSUM_EN, no chksum port or logic shall exist, and all other behaviour shall be identical.

Structure
REQ-032 Package cnn_pkg shall hold the DATA_WIDTH, OFM_SIZE, and NUM_CH defaults and the state encoding IDLE/WRITE/NEXT.
REQ-033 Sub-module ofm_row_mux (combinational selection of row `row` from the capture buffer) shall be the only sub-module.

Verification
REQ-034 Single channel: ofm pixel(i,j)=16*i+j, wr_ready tied 1, one finish -> 16 writes at addr 0..15, row r data bytes 16r..16r+15, then ch_idx=1.
REQ-035 Backpressure: wr_ready low on alternate cycles -> each row held stable until accepted, 16 writes total, no duplicate or skipped addr.
REQ-036 Full layer: 128 finishes, each after the previous channel completes -> last write addr 2047, layer_done pulses once, ch_idx returns to 0.
REQ-037 Overrun: second finish 3 cycles after the first -> overrun=1, written data comes from the first ofm only.
REQ-038 Reset mid-WRITE at row 5 -> wr=0 and ch_idx=0 immediately, no writes after release until the next finish.
REQ-039 OFM_WRITER_CHKSUM_EN build, all pixels 0x7f, one channel -> chksum=256*127 mod 65536=0x7F00.
